// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared fetch-stage types and encodings (FSM states, nop, PCSrc).
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
  localparam logic [1:0]  PCSRC_BRANCH = 2'b01;
  localparam logic [1:0]  PCSRC_JUMP   = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Purpose  : Plain modular adder, result wraps at 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_a + i_b;

endmodule : adder
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pipe_reg
// Purpose  : IF/ID pipeline register with enable and synchronous bubble clear.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pc_plus4,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_valid
);

  // Enable gates the clear as well: a stalled decode keeps its bubble or word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instr    <= WIDTH'(NOP_INSTR);
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
    end else if (i_en) begin
      if (i_clr) begin
        o_instr    <= WIDTH'(NOP_INSTR);
        o_pc_plus4 <= '0;
        o_valid    <= 1'b0;
      end else begin
        o_instr    <= i_instr;
        o_pc_plus4 <= i_pc_plus4;
        o_valid    <= 1'b1;
      end
    end
  end

endmodule : if_id_pipe_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC/fetch FSM over a req/ready instruction memory, feeding IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               PCSrcD_width = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    StallF,
  input  logic                    StallD,
  input  logic [PCSrcD_width-1:0] PCSrcD,
  input  logic [WIDTH-1:0]        PCBranchD,
  input  logic [WIDTH-1:0]        PCJumpD,
  input  logic [WIDTH-1:0]        IMemRdata,
  input  logic                    IMemReady,
  output logic                    IMemReq,
  output logic [WIDTH-1:0]        IMemAddr,
  output logic [WIDTH-1:0]        InstrD,
  output logic [WIDTH-1:0]        PCPlus4D,
  output logic                    IValidD,
  output logic                    FetchBusyF
);

  localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(4);

  fetch_state_t     r_state, w_state_next;
  logic [WIDTH-1:0] r_pcf, w_pcf_next;
  logic [WIDTH-1:0] r_redir_pc, w_redir_pc_next;
  logic [WIDTH-1:0] r_buf, w_buf_next;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_target_raw;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_deliver_word;
  logic             w_redir;
  logic             w_deliver;

  adder #(.WIDTH(WIDTH)) u_pc_adder (
    .i_a (r_pcf),
    .i_b (c_pc_step),
    .o_y (w_pc_plus4)
  );

  assign w_redir      = (PCSrcD != PCSRC_SEQ) && !StallD;
  assign w_target_raw = PCSrcD[1] ? PCJumpD : PCBranchD;
  assign w_target     = {w_target_raw[WIDTH-1:2], 2'b00};

  // PCF only moves once the in-flight request completes, so it is also the
  // held address during DISCARD.
  assign IMemAddr = r_pcf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= BOOT;
      r_pcf      <= RESET_PC;
      r_redir_pc <= RESET_PC;
      r_buf      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pcf      <= w_pcf_next;
      r_redir_pc <= w_redir_pc_next;
      r_buf      <= w_buf_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pcf_next      = r_pcf;
    w_redir_pc_next = r_redir_pc;
    w_buf_next      = r_buf;
    w_deliver       = 1'b0;
    w_deliver_word  = IMemRdata;
    IMemReq         = 1'b0;
    FetchBusyF      = 1'b0;

    case (r_state)
      BOOT: begin
        FetchBusyF   = 1'b1;
        w_state_next = FETCH;
      end

      FETCH: begin
        IMemReq    = 1'b1;
        FetchBusyF = !IMemReady;
        if (w_redir) begin
          if (IMemReady) begin
            w_pcf_next = w_target;
          end else begin
            w_redir_pc_next = w_target;
            w_state_next    = DISCARD;
          end
        end else if (IMemReady) begin
          if (!StallF) begin
            w_deliver  = 1'b1;
            w_pcf_next = w_pc_plus4;
          end else begin
            w_buf_next   = IMemRdata;
            w_state_next = HOLD;
          end
        end
      end

      HOLD: begin
        if (w_redir) begin
          w_pcf_next   = w_target;
          w_state_next = FETCH;
        end else if (!StallF) begin
          w_deliver      = 1'b1;
          w_deliver_word = r_buf;
          w_pcf_next     = w_pc_plus4;
          w_state_next   = FETCH;
        end
      end

      DISCARD: begin
        IMemReq    = 1'b1;
        FetchBusyF = 1'b1;
        if (w_redir) begin
          w_redir_pc_next = w_target;
        end
        // A redirect arriving in the completing cycle still wins.
        if (IMemReady) begin
          w_pcf_next   = w_redir ? w_target : r_redir_pc;
          w_state_next = FETCH;
        end
      end

      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  if_id_pipe_reg #(.WIDTH(WIDTH)) u_if_id (
    .clk        (CLK),
    .rst        (RST),
    .i_en       (!StallD),
    .i_clr      (!w_deliver),
    .i_instr    (w_deliver_word),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (InstrD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (IValidD)
  );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage (directed + randomized).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallF, StallD;
  logic [1:0]  PCSrcD;
  logic [31:0] PCBranchD, PCJumpD;
  logic [31:0] IMemRdata;
  logic        IMemReady;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] InstrD, PCPlus4D;
  logic        IValidD, FetchBusyF;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .PCSrcD_width(2)) dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .IMemRdata(IMemRdata),
    .IMemReady(IMemReady), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .IValidD(IValidD), .FetchBusyF(FetchBusyF)
  );

  // Program image: a distinct nonzero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'hDEAD_BEEF) * 32'h9E37_79B1) | 32'h1;
  endfunction

  assign IMemRdata = IMemReady ? mem_word(IMemAddr) : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 2'b00;
    PCBranchD = '0; PCJumpD = '0; IMemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", IMemReq); end
    checks++; if (IValidD !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", IValidD); end
    RST = 1'b0;
    tick;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL boot_req got %b/%h exp 1/0", IMemReq, IMemAddr); end
    IMemReady = 1'b1;
    tick;
    checks++; if (InstrD !== mem_word(32'h0)) begin errors++; $display("FAIL pre_rst_instr got %h exp %h", InstrD, mem_word(32'h0)); end
    // Now waiting at 0x4; pulse reset mid-request.
    IMemReady = 1'b0;
    #1;
    checks++; if (IMemAddr !== 32'h4 || IMemReq !== 1'b1) begin errors++; $display("FAIL wait4 got %b/%h exp 1/4", IMemReq, IMemAddr); end
    #1 RST = 1'b1;
    #1;
    checks++; if (InstrD !== 32'h0 || PCPlus4D !== 32'h0 || IValidD !== 1'b0) begin errors++; $display("FAIL async_rst_ifid got %h/%h/%b exp 0/0/0", InstrD, PCPlus4D, IValidD); end
    checks++; if (IMemReq !== 1'b0 || IMemAddr !== 32'h0) begin errors++; $display("FAIL async_rst_mem got %b/%h exp 0/0", IMemReq, IMemAddr); end
    RST = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL boot_noreq got %b exp 0", IMemReq); end
    tick;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || FetchBusyF !== 1'b1) begin errors++; $display("FAIL post_rst_req got %b/%h/%b exp 1/0/1", IMemReq, IMemAddr, FetchBusyF); end
  endtask

  task automatic test_sequential;
    IMemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (InstrD !== mem_word(32'(4 * i)) || PCPlus4D !== 32'(4 * (i + 1)) || IValidD !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d got %h/%h/%b exp %h/%h/1", i, InstrD, PCPlus4D, IValidD, mem_word(32'(4 * i)), 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_wait_states;
    tick;  // delivers 0xC
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (IMemAddr !== 32'h10 || FetchBusyF !== 1'b1 || IMemReq !== 1'b1) begin errors++; $display("FAIL wait%0d got %h/%b exp 10/1", i, IMemAddr, FetchBusyF); end
      tick;
      checks++; if (IValidD !== 1'b0) begin errors++; $display("FAIL wait_bubble%0d got %b exp 0", i, IValidD); end
    end
    IMemReady = 1'b1;
    #1;
    checks++; if (FetchBusyF !== 1'b0) begin errors++; $display("FAIL ready_busy got %b exp 0", FetchBusyF); end
    tick;
    checks++; if (InstrD !== mem_word(32'h10) || PCPlus4D !== 32'h14) begin errors++; $display("FAIL wait_word got %h/%h exp %h/14", InstrD, PCPlus4D, mem_word(32'h10)); end
  endtask

  task automatic test_redirect;
    PCSrcD = 2'b01; PCBranchD = 32'h43; PCJumpD = 32'h999;
    tick;
    checks++; if (IValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL br_bubble got %h/%h/%b exp 0/0/0", InstrD, PCPlus4D, IValidD); end
    checks++; if (IMemAddr !== 32'h40) begin errors++; $display("FAIL br_addr got %h exp 40", IMemAddr); end
    PCSrcD = 2'b11; PCBranchD = 32'h80; PCJumpD = 32'h100;
    tick;
    checks++; if (IMemAddr !== 32'h100 || IValidD !== 1'b0) begin errors++; $display("FAIL jmp_prio got %h/%b exp 100/0", IMemAddr, IValidD); end
    PCSrcD = 2'b00;
    tick;
    checks++; if (InstrD !== mem_word(32'h100) || PCPlus4D !== 32'h104) begin errors++; $display("FAIL jmp_word got %h/%h exp %h/104", InstrD, PCPlus4D, mem_word(32'h100)); end
  endtask

  task automatic test_discard;
    PCSrcD = 2'b01; PCBranchD = 32'h20;
    tick;
    PCSrcD = 2'b00; IMemReady = 1'b0;
    tick;
    PCSrcD = 2'b10; PCJumpD = 32'h200;
    #1;
    checks++; if (IMemAddr !== 32'h20) begin errors++; $display("FAIL pre_disc_addr got %h exp 20", IMemAddr); end
    tick;
    PCSrcD = 2'b00;
    #1;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h20 || FetchBusyF !== 1'b1 || IValidD !== 1'b0) begin errors++; $display("FAIL disc_hold got %b/%h/%b/%b exp 1/20/1/0", IMemReq, IMemAddr, FetchBusyF, IValidD); end
    tick;
    checks++; if (IMemAddr !== 32'h20 || IMemReq !== 1'b1) begin errors++; $display("FAIL disc_hold2 got %b/%h exp 1/20", IMemReq, IMemAddr); end
    IMemReady = 1'b1;
    tick;
    checks++; if (IValidD !== 1'b0 || IMemAddr !== 32'h200 || IMemReq !== 1'b1) begin errors++; $display("FAIL disc_done got %b/%h/%b exp 0/200/1", IValidD, IMemAddr, IMemReq); end
    tick;
    checks++; if (InstrD !== mem_word(32'h200) || PCPlus4D !== 32'h204) begin errors++; $display("FAIL disc_word got %h/%h exp %h/204", InstrD, PCPlus4D, mem_word(32'h200)); end
  endtask

  task automatic test_stall_hold;
    StallF = 1'b1; StallD = 1'b1;
    tick;  // capture 0x204 into the buffer
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (InstrD !== mem_word(32'h200) || PCPlus4D !== 32'h204 || IValidD !== 1'b1 || IMemReq !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d got %h/%h/%b/%b exp %h/204/1/0", i, InstrD, PCPlus4D, IValidD, IMemReq, mem_word(32'h200));
      end
    end
    StallF = 1'b0; StallD = 1'b0;
    tick;
    checks++; if (InstrD !== mem_word(32'h204) || PCPlus4D !== 32'h208 || IValidD !== 1'b1) begin errors++; $display("FAIL hold_release got %h/%h exp %h/208", InstrD, PCPlus4D, mem_word(32'h204)); end
    tick;
    checks++; if (InstrD !== mem_word(32'h208) || PCPlus4D !== 32'h20C) begin errors++; $display("FAIL hold_once got %h/%h exp %h/20c", InstrD, PCPlus4D, mem_word(32'h208)); end
  endtask

  task automatic test_wrap;
    PCSrcD = 2'b10; PCJumpD = 32'hFFFF_FFFF;
    tick;
    checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", IMemAddr); end
    PCSrcD = 2'b00;
    tick;
    checks++; if (InstrD !== mem_word(32'hFFFF_FFFC) || PCPlus4D !== 32'h0 || IValidD !== 1'b1) begin errors++; $display("FAIL wrap_word got %h/%h/%b exp %h/0/1", InstrD, PCPlus4D, IValidD, mem_word(32'hFFFF_FFFC)); end
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", IMemAddr); end
  endtask

  // Program-order model: every delivered word is the next sequential address
  // after the last delivered one, or the latest redirect target since then.
  task automatic test_random;
    logic [31:0] exp_pc, tgt, pend_addr, h_instr, h_pc4;
    logic        redir, pend, h_v;
    int          delivered;
    exp_pc = '0; pend = 1'b0; pend_addr = '0; delivered = 0;
    RST = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 2'b00; IMemReady = 1'b0;
    tick;
    RST = 1'b0;
    tick;  // quiet boot cycle
    for (int n = 0; n < 3000; n++) begin
      IMemReady = ($urandom_range(0, 2) != 0);
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = StallF && ($urandom_range(0, 1) == 1);
      PCSrcD    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      PCBranchD = $urandom;
      PCJumpD   = $urandom;
      #1;
      redir = (PCSrcD != 2'b00) && !StallD;
      tgt   = (PCSrcD[1] ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
      if (pend) begin
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== pend_addr) begin errors++; $display("FAIL rnd_stable n=%0d got %b/%h exp 1/%h", n, IMemReq, IMemAddr, pend_addr); end
      end
      if (IMemReq === 1'b1 && IMemReady === 1'b0) begin
        checks++;
        if (FetchBusyF !== 1'b1) begin errors++; $display("FAIL rnd_busy n=%0d got %b exp 1", n, FetchBusyF); end
      end
      pend = (IMemReq === 1'b1) && !IMemReady;
      pend_addr = IMemAddr;
      h_instr = InstrD; h_pc4 = PCPlus4D; h_v = IValidD;
      tick;
      checks++;
      if (StallD) begin
        if (InstrD !== h_instr || PCPlus4D !== h_pc4 || IValidD !== h_v) begin errors++; $display("FAIL rnd_held n=%0d got %h/%h/%b exp %h/%h/%b", n, InstrD, PCPlus4D, IValidD, h_instr, h_pc4, h_v); end
      end else if (redir || IValidD !== 1'b1) begin
        if (IValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL rnd_bubble n=%0d got %h/%h/%b exp 0/0/0", n, InstrD, PCPlus4D, IValidD); end
      end else begin
        if (InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'h4) begin errors++; $display("FAIL rnd_order n=%0d got %h/%h exp %h/%h", n, InstrD, PCPlus4D, mem_word(exp_pc), exp_pc + 32'h4); end
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
      if (redir) exp_pc = tgt;
    end
    checks++;
    if (delivered < 300) begin errors++; $display("FAIL rnd_progress got %0d exp >=300", delivered); end
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 2'b00;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_wait_states;
    test_redirect;
    test_discard;
    test_stall_hold;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule : tb_fetch_stage
`default_nettype wire
